// File: rtl/inst_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue: entry layout,
// default depth and the occupancy-state encoding.
package inst_queue_pkg;

  localparam int IQ_DEPTH_DEFAULT = 4;

  // Entry layout, MSB first: {adef, pc, inst}
  localparam int IQ_ENTRY_W  = 65;
  localparam int IQ_INST_LSB = 0;
  localparam int IQ_PC_LSB   = 32;
  localparam int IQ_ADEF_BIT = 64;

  typedef struct packed {
    logic        adef;
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  // The queue's only "state machine" is its occupancy; this names its regions.
  typedef enum logic [1:0] {
    IQ_EMPTY   = 2'd0,
    IQ_PARTIAL = 2'd1,
    IQ_FULL    = 2'd2
  } iq_state_e;

  function automatic logic [IQ_ENTRY_W-1:0] iq_pack(input logic adef,
                                                    input logic [31:0] pc,
                                                    input logic [31:0] inst);
    iq_entry_t e;
    e.adef = adef;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/iq_storage.sv
// Entry array for inst_queue: synchronous write, asynchronous read at the head
// pointer, synchronous clear of every entry on reset.
module iq_storage
  import inst_queue_pkg::*;
#(
  parameter  int DEPTH = IQ_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [PTR_W-1:0]      wr_ptr,
  input  logic [IQ_ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]      rd_ptr,
  output logic [IQ_ENTRY_W-1:0] rdata
);

  logic [IQ_ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular FIFO with occupancy counter,
// one-cycle flush, optional empty-queue bypass under INST_QUEUE_BYPASS_EN.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter  int DEPTH = IQ_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fs_valid,
  input  logic [31:0]      fs_pc,
  input  logic [31:0]      fs_inst,
  input  logic             fs_adef,
  output logic             iq_allowin,
  output logic             ds_valid,
  output logic [31:0]      ds_pc,
  output logic [31:0]      ds_inst,
  output logic             ds_adef,
  input  logic             ds_allowin,
  input  logic             flush,
  output logic [PTR_W:0]   iq_count
);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic [IQ_ENTRY_W-1:0] head_raw;
  iq_entry_t             head;
  iq_state_e             iq_state;
  logic                  head_valid;
  logic                  bypass_take;
  logic                  enq;
  logic                  deq;

  // Handshake: an entry moves on a rising edge when its valid and the
  // receiver's allowin are both high; iq_allowin never looks at ds_allowin.
  always_comb begin
    iq_state = IQ_PARTIAL;
    if (count == '0) begin
      iq_state = IQ_EMPTY;
    end else if (count == FULL_COUNT) begin
      iq_state = IQ_FULL;
    end
  end

  assign head       = iq_entry_t'(head_raw);
  assign head_valid = (iq_state != IQ_EMPTY);
  assign iq_allowin = (iq_state != IQ_FULL);
  assign iq_count   = count;

`ifdef INST_QUEUE_BYPASS_EN
  // While empty, the fetch entry is offered straight to decode; if decode
  // takes it, it never touches storage.
  assign bypass_take = ~head_valid & fs_valid & ds_allowin & ~flush;

  always_comb begin
    ds_valid = ~flush & (head_valid | fs_valid);
    ds_pc    = head.pc;
    ds_inst  = head.inst;
    ds_adef  = head.adef;
    if (!head_valid) begin
      ds_pc   = fs_pc;
      ds_inst = fs_inst;
      ds_adef = fs_adef;
    end
  end
`else
  assign bypass_take = 1'b0;
  assign ds_valid    = head_valid;
  assign ds_pc       = head.pc;
  assign ds_inst     = head.inst;
  assign ds_adef     = head.adef;
`endif

  assign enq = fs_valid & iq_allowin & ~bypass_take;
  assign deq = head_valid & ds_allowin;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  iq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk    (clk),
    .reset  (reset),
    .we     (enq & ~flush),
    .wr_ptr (wr_ptr),
    .wdata  (iq_pack(fs_adef, fs_pc, fs_inst)),
    .rd_ptr (rd_ptr),
    .rdata  (head_raw)
  );

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed vector table, hand-written corner sequences,
// and a randomized phase checked against a queue-based reference model.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);
`ifdef INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] P = 32'h1c00_0000;

  logic             clk;
  logic             reset;
  logic             fs_valid;
  logic [31:0]      fs_pc;
  logic [31:0]      fs_inst;
  logic             fs_adef;
  logic             iq_allowin;
  logic             ds_valid;
  logic [31:0]      ds_pc;
  logic [31:0]      ds_inst;
  logic             ds_adef;
  logic             ds_allowin;
  logic             flush;
  logic [PTR_W:0]   iq_count;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .fs_valid   (fs_valid),
    .fs_pc      (fs_pc),
    .fs_inst    (fs_inst),
    .fs_adef    (fs_adef),
    .iq_allowin (iq_allowin),
    .ds_valid   (ds_valid),
    .ds_pc      (ds_pc),
    .ds_inst    (ds_inst),
    .ds_adef    (ds_adef),
    .ds_allowin (ds_allowin),
    .flush      (flush),
    .iq_count   (iq_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: entries the queue must hold, oldest first, as {adef, pc, inst}
  logic [IQ_ENTRY_W-1:0] exp_q[$];

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic        al;
    logic        fl;
    int          cnt;
    logic        val;
    logic        ain;
    int          chk;   // 0: skip data, 1: head entry of hpc, 2: all-zero data
    logic [31:0] hpc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5a5a_0000;
  endfunction

  function automatic logic adef_of(input logic [31:0] pc);
    return pc[3];
  endfunction

  function automatic vec_t v(input logic fv, input logic [31:0] pc, input logic al,
                             input logic fl, input int cnt, input logic val,
                             input logic ain, input int chk, input logic [31:0] hpc);
    vec_t r;
    r.fv = fv; r.pc = pc; r.al = al; r.fl = fl; r.cnt = cnt;
    r.val = val; r.ain = ain; r.chk = chk; r.hpc = hpc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: called 1 time unit after a rising edge; leaves outputs settled.
  task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic adef, input logic al, input logic fl, input logic rs);
    fs_valid   = fv;
    fs_pc      = pc;
    fs_inst    = inst;
    fs_adef    = adef;
    ds_allowin = al;
    flush      = fl;
    reset      = rs;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input logic al, input logic fl, input logic rs);
    drive(1'b0, 32'h0, 32'h0, 1'b0, al, fl, rs);
  endtask

  task automatic drive_pc(input logic [31:0] pc, input logic al, input logic fl);
    drive(1'b1, pc, inst_of(pc), adef_of(pc), al, fl, 1'b0);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc,
                            input logic [31:0] inst, input logic adef);
    check({tag, ".ds_pc"},   ds_pc,          pc);
    check({tag, ".ds_inst"}, ds_inst,        inst);
    check({tag, ".ds_adef"}, 32'(ds_adef),   32'(adef));
  endtask

  task automatic check_ctl(input string tag, input int cnt, input logic val, input logic ain);
    check({tag, ".iq_count"},   32'(iq_count),   32'(cnt));
    check({tag, ".ds_valid"},   32'(ds_valid),   32'(val));
    check({tag, ".iq_allowin"}, 32'(iq_allowin), 32'(ain));
  endtask

  initial begin
    logic        fv, al, fl, rs, adef, e_valid;
    logic [31:0] pc, inst;
    logic [IQ_ENTRY_W-1:0] e_head;
    int          size;
    string       tag;

    // Each row lists this cycle's inputs and the outputs expected before the edge.
    for (int i = 0; i < 3; i++) vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 2, 0));
    vecs.push_back(v(1, P,       0, 0, 0, BYP, 1, BYP ? 1 : 0, P));
    vecs.push_back(v(1, P+4,     0, 0, 1, 1, 1, 1, P));
    vecs.push_back(v(1, P+8,     0, 0, 2, 1, 1, 1, P));
    vecs.push_back(v(1, P+'hc,   0, 0, 3, 1, 1, 1, P));
    vecs.push_back(v(1, P+'h10,  0, 0, 4, 1, 0, 1, P));
    vecs.push_back(v(1, P+'h10,  1, 0, 4, 1, 0, 1, P));
    vecs.push_back(v(1, P+'h10,  1, 0, 3, 1, 1, 1, P+4));
    vecs.push_back(v(1, P+'h14,  1, 0, 3, 1, 1, 1, P+8));
    vecs.push_back(v(1, P+'h18,  1, 0, 3, 1, 1, 1, P+'hc));
    vecs.push_back(v(1, P+'h1c,  1, 0, 3, 1, 1, 1, P+'h10));
    vecs.push_back(v(1, P+'h20,  1, 0, 3, 1, 1, 1, P+'h14));
    vecs.push_back(v(0, 0,       1, 0, 3, 1, 1, 1, P+'h18));
    vecs.push_back(v(1, P+'h24,  1, 0, 2, 1, 1, 1, P+'h1c));
    vecs.push_back(v(0, 0,       0, 0, 2, 1, 1, 1, P+'h20));
    vecs.push_back(v(1, P+'h28,  0, 0, 2, 1, 1, 1, P+'h20));
    vecs.push_back(v(1, P+'h2c,  1, 1, 3, !BYP, 1, BYP ? 0 : 1, P+'h20));
    vecs.push_back(v(0, 0,       0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(1, P+'h30,  0, 0, 0, BYP, 1, BYP ? 1 : 0, P+'h30));
    vecs.push_back(v(0, 0,       0, 0, 1, 1, 1, 1, P+'h30));
    vecs.push_back(v(0, 0,       1, 0, 1, 1, 1, 1, P+'h30));
    vecs.push_back(v(0, 0,       0, 0, 0, 0, 1, 0, 0));

    // Reset
    drive_idle(1'b0, 1'b0, 1'b1);
    tick();
    drive_idle(1'b0, 1'b0, 1'b1);
    tick();

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      if (vecs[i].fv) drive_pc(vecs[i].pc, vecs[i].al, vecs[i].fl);
      else            drive_idle(vecs[i].al, vecs[i].fl, 1'b0);
      check_ctl(tag, vecs[i].cnt, vecs[i].val, vecs[i].ain);
      if (vecs[i].chk == 1) check_head(tag, vecs[i].hpc, inst_of(vecs[i].hpc), adef_of(vecs[i].hpc));
      else if (vecs[i].chk == 2) check_head(tag, 32'h0, 32'h0, 1'b0);
      tick();
    end

    // Empty queue with fetch and decode both ready on the same cycle
    drive(1'b1, P+'h100, 32'h0280_0c21, 1'b0, 1'b1, 1'b0, 1'b0);
    check_ctl("byp0", 0, BYP, 1'b1);
    if (BYP) check_head("byp0", P+'h100, 32'h0280_0c21, 1'b0);
    tick();
    drive_idle(1'b1, 1'b0, 1'b0);
    if (BYP) begin
      check_ctl("byp1", 0, 1'b0, 1'b1);
    end else begin
      check_ctl("byp1", 1, 1'b1, 1'b1);
      check_head("byp1", P+'h100, 32'h0280_0c21, 1'b0);
    end
    tick();
    drive_idle(1'b0, 1'b0, 1'b0);
    check_ctl("byp2", 0, 1'b0, 1'b1);
    tick();

    // Reset mid-stream overrides a concurrent handshake and clears storage
    drive_pc(P+'h200, 1'b0, 1'b0);
    tick();
    drive_pc(P+'h204, 1'b0, 1'b0);
    tick();
    drive(1'b1, P+'h208, inst_of(P+'h208), 1'b1, 1'b1, 1'b0, 1'b1);
    check_ctl("rst0", 2, 1'b1, 1'b1);
    check_head("rst0", P+'h200, inst_of(P+'h200), adef_of(P+'h200));
    tick();
    drive_idle(1'b0, 1'b0, 1'b0);
    check_ctl("rst1", 0, 1'b0, 1'b1);
    check_head("rst1", 32'h0, 32'h0, 1'b0);
    tick();

    // Randomized traffic against the scoreboard model
    exp_q.delete();
    for (int n = 0; n < 600; n++) begin
      fv   = ($urandom_range(0, 9) < 7);
      al   = ($urandom_range(0, 9) < 5);
      fl   = ($urandom_range(0, 59) == 0);
      rs   = ($urandom_range(0, 99) == 0);
      pc   = $urandom;
      inst = $urandom;
      adef = 1'($urandom_range(0, 1));
      drive(fv, pc, inst, adef, al, fl, rs);

      size = exp_q.size();
      if (BYP && size == 0) begin
        e_valid = fv && !fl;
        e_head  = {adef, pc, inst};
      end else begin
        e_valid = (size != 0) && !(BYP && fl);
        e_head  = (size != 0) ? exp_q[0] : '0;
      end
      tag = $sformatf("rnd%0d", n);
      check_ctl(tag, size, e_valid, size < DEPTH);
      if (e_valid) check_head(tag, e_head[63:32], e_head[31:0], e_head[64]);

      if (rs || fl) begin
        exp_q.delete();
      end else if (!(BYP && size == 0 && fv && al)) begin
        if (size > 0 && al) void'(exp_q.pop_front());
        if (fv && size < DEPTH) exp_q.push_back({adef, pc, inst});
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch stage and the decode stage. Fetched {pc, inst, adef} triples are buffered in a small circular FIFO so fetch keeps running while decode stalls. Decode consumes the head entry through a valid/allowin handshake, and the opcode-field decoders read the head instruction. A branch or exception flush empties the queue in one cycle.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2
- PTR_W, $clog2(DEPTH): pointer width; derived, not overridden
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- fs_valid  in  1  fetch presents an entry
- fs_pc  in  32  PC of the fetched instruction
- fs_inst  in  32  instruction word
- fs_adef  in  1  fetch address exception flag
- iq_allowin  out  1  queue accepts an entry this cycle
- ds_valid  out  1  head entry valid to decode
- ds_pc  out  32  head PC
- ds_inst  out  32  head instruction
- ds_adef  out  1  head exception flag
- ds_allowin  in  1  decode consumes head this cycle
- flush  in  1  discard all entries (branch/exception redirect)
- iq_count  out  PTR_W+1  current occupancy, 0..DEPTH

## Operation
- Enqueue when fs_valid & iq_allowin: write to wr_ptr, wr_ptr+1.
- Dequeue when ds_valid & ds_allowin: rd_ptr+1.
- iq_allowin = (count != DEPTH). It does not depend on ds_allowin, so a full queue stalls fetch even on a dequeue cycle.
- ds_valid = (count != 0); ds_* is driven combinationally from the entry at rd_ptr.
- Count update:
  - +1 on enqueue only
  - −1 on dequeue only
  - unchanged on simultaneous enqueue and dequeue
- Pointers are PTR_W bits and wrap modulo DEPTH with no special case. Full and empty are distinguished by count only.
- Empty queue with fs_valid high: the entry is written and ds_valid stays low this cycle (no bypass unless configured).
- Full queue with ds_allowin high: dequeue happens and no enqueue happens.
- flush has priority over everything:
  - count, wr_ptr and rd_ptr go to 0
  - any enqueue or dequeue in the same cycle is ignored
  - iq_allowin is still computed from the pre-flush count in that cycle
- reset has the same effect as flush, and in addition clears all storage entries to 0.
- There is no state machine beyond the occupancy counter. States are EMPTY (count 0), PARTIAL, and FULL (count DEPTH), and transitions follow the count rules above.

## Timing
- Reset values:
  - iq_count=0, ds_valid=0, iq_allowin=1
  - ds_pc=0, ds_inst=0, ds_adef=0
  - With INST_QUEUE_BYPASS_EN, ds_* follow fs_* while empty (see Configuration).
- Latency without bypass: an entry enqueued at edge N appears on ds_* in the cycle after N, so the minimum is 1 cycle.
- Throughput: 1 entry/cycle in and out while 0 < count < DEPTH.
- Effect of flush asserted in cycle N:
  - After edge N: ds_valid=0, iq_allowin=1.
  - An fs_valid entry in cycle N is lost. Fetch must re-present from the redirected PC.
- Reset asserted mid-stream acts on the next edge regardless of any handshake.

## Configuration
- INST_QUEUE_BYPASS_EN defined:
  - When count==0 and fs_valid=1, ds_valid=1 and ds_* = fs_* combinationally.
  - If ds_allowin is also 1, the entry is consumed without being written and count stays 0.
  - If ds_allowin is 0, the entry is written normally.
  - flush forces ds_valid=0 in its cycle.
- Not defined: no combinational fs→ds path; minimum latency is 1 cycle; ds_valid is a pure function of the count register.

## Structure
- The shared header holds:
  - IQ_ENTRY_W = 65
  - the entry field offsets {adef, pc, inst}
  - the default DEPTH
- One sub-module, iq_storage:
  - DEPTH×IQ_ENTRY_W register array
  - synchronous write port
  - asynchronous read port at rd_ptr
  - synchronous clear on reset
- inst_queue keeps the pointers, the count, the handshake and the bypass mux.

## Test plan
- Reset, then idle 3 cycles → ds_valid=0, iq_allowin=1, iq_count=0, ds_inst=0.
- Enqueue pc 0x1c000000..0x1c00000c with ds_allowin=0 → iq_count=4, iq_allowin=0. A 5th fs_valid is not accepted.
- From full, ds_allowin=1 for 6 cycles while fetch streams 0x1c000010+ → outputs in strict PC order. In the first cycle after full, iq_count=3. Pointer wrap causes no loss.
- Count=2, fs_valid=1 and ds_allowin=1 on the same edge → count stays 2, head advances by one entry.
- Count=3, flush=1 with fs_valid=1 and ds_allowin=1 → next cycle count=0, ds_valid=0. The flush-cycle fs entry never appears.
- With INST_QUEUE_BYPASS_EN: empty queue, fs_valid=1 with fs_inst=0x02800c21 and ds_allowin=1 → ds_valid=1 and ds_inst=0x02800c21 in the same cycle, count stays 0. Without the macro, the same stimulus gives ds_valid=0 that cycle and 1 in the next.
